// File: rtl/rwt_unpack_arbiter_if.sv
// Bundle of the arbiter's source-side and unpacker-side AXIS signals.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment that drives the sources and the unpacker ready.
interface rwt_unpack_arbiter_if #(
    parameter int NUM_SRC = 2,
    parameter int DWIDTH  = 64,
    parameter int EWIDTH  = 4
);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC*DWIDTH-1:0] s_axi_data;
    logic [NUM_SRC-1:0]        s_axi_valid;
    logic [NUM_SRC-1:0]        s_axi_ready;
    logic [NUM_SRC-1:0]        s_axi_last;
    logic [NUM_SRC*EWIDTH-1:0] s_axi_enables;

    logic [DWIDTH-1:0]         m_axi_data;
    logic                      m_axi_valid;
    logic                      m_axi_ready;
    logic                      m_axi_last;
    logic [EWIDTH-1:0]         m_axi_enables;
    logic [SW-1:0]             m_axi_src;
    logic [15:0]               drop_count;

    modport master (
        output s_axi_data, s_axi_valid, s_axi_last, s_axi_enables, m_axi_ready,
        input  s_axi_ready, m_axi_data, m_axi_valid, m_axi_last, m_axi_enables,
               m_axi_src, drop_count
    );

    modport slave (
        input  s_axi_data, s_axi_valid, s_axi_last, s_axi_enables, m_axi_ready,
        output s_axi_ready, m_axi_data, m_axi_valid, m_axi_last, m_axi_enables,
               m_axi_src, drop_count
    );
endinterface

// File: rtl/rwt_unpack_arbiter.sv
// Packet-level round-robin arbiter in front of a single rwt_sample_unpack.
// A source is granted for a whole packet. Its enable mask is latched at grant
// and held on m_axi_enables until the next grant. Packets with an all-zero mask
// are swallowed, because the unpacker cannot process them, and are counted in a
// saturating drop counter.
module rwt_unpack_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int DWIDTH  = 64,
    parameter int EWIDTH  = 4
) (
    input  logic clk,
    input  logic reset,
    rwt_unpack_arbiter_if.slave bus
);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t             state_reg, state_next;
    logic [SW-1:0]      grant_reg, grant_next;
    logic [SW-1:0]      rr_reg, rr_next;
    logic [EWIDTH-1:0]  mask_reg, mask_next;
    logic [15:0]        drop_count_reg, drop_count_next;

    logic [DWIDTH-1:0]  data_arr    [NUM_SRC];
    logic [EWIDTH-1:0]  enables_arr [NUM_SRC];

    logic               found;
    logic [SW-1:0]      pick;
    logic [SW-1:0]      rr_after;
    logic [NUM_SRC-1:0] s_ready;
    logic               m_valid;
    logic               m_last;

    // Split the flat source buses into per-source lanes.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
        assign data_arr[gi]    = bus.s_axi_data[gi*DWIDTH +: DWIDTH];
        assign enables_arr[gi] = bus.s_axi_enables[gi*EWIDTH +: EWIDTH];
    end

    // Round-robin search: the first valid source at or after the rr pointer, with wrap.
    always_comb begin
        int idx;
        logic [SW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            cand = SW'(idx);
            if (!found && bus.s_axi_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // The source after the granted one becomes the highest-priority source for the next search.
    assign rr_after = (grant_reg == SW'(NUM_SRC - 1)) ? '0 : grant_reg + SW'(1);

    // Next-state logic and the combinational routing of handshakes.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        mask_next       = mask_reg;
        rr_next         = rr_reg;
        drop_count_next = drop_count_reg;
        s_ready         = '0;
        m_valid         = 1'b0;
        m_last          = 1'b0;
        case (state_reg)
            IDLE: begin
                // Grant cycle: nothing transfers; the winner and its mask are registered.
                if (found) begin
                    grant_next = pick;
                    mask_next  = enables_arr[pick];
                    state_next = (enables_arr[pick] != '0) ? PASS : DROP;
                end
            end
            PASS: begin
                m_valid            = bus.s_axi_valid[grant_reg];
                m_last             = bus.s_axi_last[grant_reg];
                s_ready[grant_reg] = bus.m_axi_ready;
                if (bus.s_axi_valid[grant_reg] && bus.m_axi_ready && bus.s_axi_last[grant_reg]) begin
                    rr_next    = rr_after;
                    state_next = IDLE;
                end
            end
            DROP: begin
                // Swallow the packet without presenting anything to the unpacker.
                s_ready[grant_reg] = 1'b1;
                if (bus.s_axi_valid[grant_reg] && bus.s_axi_last[grant_reg]) begin
                    if (drop_count_reg != 16'hFFFF) begin
                        drop_count_next = drop_count_reg + 16'd1;
                    end
                    rr_next    = rr_after;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and latched-grant registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            rr_reg         <= '0;
            mask_reg       <= '0;
            drop_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            rr_reg         <= rr_next;
            mask_reg       <= mask_next;
            drop_count_reg <= drop_count_next;
        end
    end

    assign bus.s_axi_ready   = s_ready;
    assign bus.m_axi_valid   = m_valid;
    assign bus.m_axi_last    = m_last;
    assign bus.m_axi_data    = data_arr[grant_reg];
    assign bus.m_axi_enables = mask_reg;
    assign bus.m_axi_src     = grant_reg;
    assign bus.drop_count    = drop_count_reg;
endmodule

// File: tb/tb_rwt_unpack_arbiter.sv
// Randomized bench for rwt_unpack_arbiter.
// A packet-level reference model predicts grants, masks, drops and the beat stream.
module tb_rwt_unpack_arbiter;
    localparam int N    = 3;
    localparam int DW   = 64;
    localparam int EW   = 4;
    localparam int NPKT = 30;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rwt_unpack_arbiter_if #(.NUM_SRC(N), .DWIDTH(DW), .EWIDTH(EW)) bus();

    rwt_unpack_arbiter #(.NUM_SRC(N), .DWIDTH(DW), .EWIDTH(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Source packet lists.
    int            pkt_len  [N][NPKT];
    logic [EW-1:0] pkt_mask [N][NPKT];
    int            pidx     [N];
    int            bidx     [N];

    // Values driven this cycle.
    bit vld [N];
    bit lst [N];
    bit mrdy;

    // Reference model state.
    int            owner;
    int            rr;
    int            drops;
    int            lat_src;
    logic [EW-1:0] lat_mask;
    bit            drop_mode;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] beat_data(input int s, input int p, input int b);
        return {8'(s), 16'(p), 16'(b), 24'h5A3C96};
    endfunction

    function automatic bit all_done();
        for (int s = 0; s < N; s++)
            if (pidx[s] < NPKT) return 1'b0;
        return 1'b1;
    endfunction

    task automatic gen_packets(input int zero_pct, input int minlen, input int maxlen);
        for (int s = 0; s < N; s++) begin
            for (int p = 0; p < NPKT; p++) begin
                pkt_len[s][p]  = $urandom_range(maxlen, minlen);
                pkt_mask[s][p] = ($urandom_range(99, 0) < zero_pct) ? '0 : EW'($urandom_range(15, 1));
            end
            pidx[s] = 0;
            bidx[s] = 0;
        end
    endtask

    task automatic model_reset();
        owner     = -1;
        rr        = 0;
        drops     = 0;
        lat_src   = 0;
        lat_mask  = '0;
        drop_mode = 1'b0;
    endtask

    task automatic drive(input int vpct, input int rpct);
        logic [N*DW-1:0] d;
        logic [N-1:0]    v;
        logic [N-1:0]    l;
        logic [N*EW-1:0] e;
        d = '0; v = '0; l = '0; e = '0;
        for (int s = 0; s < N; s++) begin
            vld[s] = 1'b0;
            lst[s] = 1'b0;
            if (pidx[s] < NPKT) begin
                vld[s] = ($urandom_range(99, 0) < vpct);
                lst[s] = (bidx[s] == pkt_len[s][pidx[s]] - 1);
                d[s*DW +: DW] = beat_data(s, pidx[s], bidx[s]);
                // Before the first beat the packet's mask is shown; afterwards junk that must be ignored.
                e[s*EW +: EW] = (bidx[s] == 0) ? pkt_mask[s][pidx[s]] : EW'($urandom);
            end
            v[s] = vld[s];
            l[s] = lst[s];
        end
        mrdy = ($urandom_range(99, 0) < rpct);
        bus.s_axi_data    = d;
        bus.s_axi_valid   = v;
        bus.s_axi_last    = l;
        bus.s_axi_enables = e;
        bus.m_axi_ready   = mrdy;
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_ready;
        bit           exp_valid;
        bit           exp_last;
        exp_ready = '0;
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        if (owner >= 0) begin
            exp_ready[owner] = drop_mode ? 1'b1 : mrdy;
            if (!drop_mode) begin
                exp_valid = vld[owner];
                exp_last  = lst[owner];
            end
        end
        check("s_ready",   64'(bus.s_axi_ready),   64'(exp_ready));
        check("m_valid",   64'(bus.m_axi_valid),   64'(exp_valid));
        check("m_last",    64'(bus.m_axi_last),    64'(exp_last));
        check("m_enables", 64'(bus.m_axi_enables), 64'(lat_mask));
        check("m_src",     64'(bus.m_axi_src),     64'(lat_src));
        check("drop_cnt",  64'(bus.drop_count),    64'(drops));
        if (exp_valid)
            check("m_data", bus.m_axi_data, beat_data(owner, pidx[owner], bidx[owner]));
    endtask

    task automatic model_step();
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int s;
                s = (rr + k) % N;
                if (vld[s]) begin
                    owner     = s;
                    lat_src   = s;
                    lat_mask  = pkt_mask[s][pidx[s]];
                    drop_mode = (lat_mask == '0);
                    break;
                end
            end
        end else if (vld[owner] && (drop_mode || mrdy)) begin
            if (bidx[owner] == pkt_len[owner][pidx[owner]] - 1) begin
                $display("pkt src=%0d id=%0d len=%0d mask=%h %s", owner, pidx[owner],
                         pkt_len[owner][pidx[owner]], lat_mask, drop_mode ? "dropped" : "passed");
                if (drop_mode && drops < 65535) drops++;
                pidx[owner]++;
                bidx[owner] = 0;
                rr    = (owner + 1) % N;
                owner = -1;
            end else begin
                bidx[owner]++;
            end
        end
    endtask

    task automatic step(input int vpct, input int rpct);
        drive(vpct, rpct);
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_phase(input int vpct, input int rpct, input int limit);
        int cyc;
        cyc = 0;
        while (!all_done() && cyc < limit) begin
            step(vpct, rpct);
            cyc++;
        end
        check("phase_complete", 64'(all_done()), 64'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_s_ready",   64'(bus.s_axi_ready),   64'd0);
        check("rst_m_valid",   64'(bus.m_axi_valid),   64'd0);
        check("rst_m_last",    64'(bus.m_axi_last),    64'd0);
        check("rst_m_enables", 64'(bus.m_axi_enables), 64'd0);
        check("rst_m_src",     64'(bus.m_axi_src),     64'd0);
        check("rst_drop_cnt",  64'(bus.drop_count),    64'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        bus.s_axi_data    = '0;
        bus.s_axi_valid   = '0;
        bus.s_axi_last    = '0;
        bus.s_axi_enables = '0;
        bus.m_axi_ready   = 1'b0;
        for (int s = 0; s < N; s++) begin
            vld[s] = 1'b0;
            lst[s] = 1'b0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Mixed traffic: bubbles, backpressure, zero-mask drops, mid-packet mask churn.
        gen_packets(25, 1, 6);
        run_phase(85, 70, 5000);

        // Fairness: everything always valid, no backpressure.
        gen_packets(0, 3, 3);
        run_phase(100, 100, 5000);

        // Back-to-back single-beat packets with sparse unpacker ready.
        gen_packets(15, 1, 1);
        run_phase(100, 20, 5000);

        // Reset in the middle of a 5-beat packet.
        gen_packets(0, 5, 5);
        cyc = 0;
        while (!(owner >= 0 && bidx[owner] == 2) && cyc < 200) begin
            step(100, 100);
            cyc++;
        end
        check("reached_beat2", 64'(owner >= 0 && bidx[owner] == 2), 64'd1);
        reset = 1'b1;
        drive(100, 100);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        gen_packets(20, 1, 6);
        run_phase(100, 100, 5000);
        gen_packets(30, 1, 6);
        run_phase(60, 50, 8000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
